// File: rtl/cp0_intr_ctrl.sv
// CP0 Status/Cause/EPC registers and an N-line edge-triggered interrupt controller.
// Line 0 has the highest priority; acknowledge saves EPC, sets EXL and retires the serviced line.
module cp0_intr_ctrl #(
  parameter int N_IRQ   = 4,
  parameter int PC_BITS = 30,
  parameter int ID_BITS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               w_en,
  input  logic [4:0]         w_req,
  input  logic [31:0]        w_data,
  input  logic [4:0]         r_req,
  output logic [31:0]        r_data,
  input  logic [N_IRQ-1:0]   irq,
  input  logic               intr_ack,
  input  logic [PC_BITS-1:0] ack_pc,
  input  logic               eret,
  output logic               intr_req,
  output logic [ID_BITS-1:0] intr_id,
  output logic [PC_BITS-1:0] epc,
  output logic               intr_en,
  output logic [N_IRQ-1:0]   intr_mask
);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  logic               status_ie;
  logic               status_exl;
  logic [N_IRQ-1:0]   status_im;
  logic [N_IRQ-1:0]   pending;
  logic [N_IRQ-1:0]   irq_prev;
  logic [PC_BITS-1:0] epc_q;

  logic [N_IRQ-1:0]   act;
  logic [N_IRQ-1:0]   irq_rise;
  logic [N_IRQ-1:0]   clr_mask;
  logic [ID_BITS-1:0] id_sel;
  logic               ack_fire;
  logic               status_wr;
  logic               epc_wr;
  logic               unused_w_data;

  assign act       = pending & status_im;
  assign irq_rise  = irq & ~irq_prev;
  assign intr_req  = status_ie & ~status_exl & (|act);
  assign ack_fire  = intr_ack & intr_req;
  assign status_wr = w_en && (w_req == REG_STATUS);
  assign epc_wr    = w_en && (w_req == REG_EPC);

  assign intr_id   = id_sel;
  assign epc       = epc_q;
  assign intr_en   = status_ie;
  assign intr_mask = status_im;

  // Only some w_data bits land in registers; reference the whole bus once.
  assign unused_w_data = ^w_data;

  // Scan from the top down so the lowest active index wins.
  always_comb begin
    id_sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (act[i]) id_sel = ID_BITS'(i);
    end
  end

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      clr_mask[i] = ack_fire && (id_sel == ID_BITS'(i));
    end
  end

  // A new edge on the serviced line wins over its clear, so the OR comes last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_ie  <= 1'b0;
      status_exl <= 1'b0;
      status_im  <= '0;
      pending    <= '0;
      irq_prev   <= '0;
      epc_q      <= '0;
    end else begin
      irq_prev <= irq;
      pending  <= (pending & ~clr_mask) | irq_rise;

      if (status_wr) begin
        status_ie <= w_data[0];
        status_im <= w_data[8 +: N_IRQ];
      end

      if (ack_fire)       status_exl <= 1'b1;
      else if (eret)      status_exl <= 1'b0;
      else if (status_wr) status_exl <= w_data[1];

      if (ack_fire)    epc_q <= ack_pc;
      else if (epc_wr) epc_q <= w_data[PC_BITS-1:0];
    end
  end

  always_comb begin
    r_data = 32'h0;
    case (r_req)
      REG_STATUS: begin
        r_data[0]          = status_ie;
        r_data[1]          = status_exl;
        r_data[8 +: N_IRQ] = status_im;
      end
      REG_CAUSE: r_data[8 +: N_IRQ]   = pending;
      REG_EPC:   r_data[PC_BITS-1:0]  = epc_q;
      default:   r_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// Bench for cp0_intr_ctrl: directed scenarios then randomized traffic,
// all checked against a register-level reference model of the CP0 rules.
module tb_cp0_intr_ctrl;

  localparam int N   = 4;
  localparam int PCB = 30;
  localparam int IDB = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           w_en;
  logic [4:0]     w_req;
  logic [31:0]    w_data;
  logic [4:0]     r_req;
  logic [31:0]    r_data;
  logic [N-1:0]   irq;
  logic           intr_ack;
  logic [PCB-1:0] ack_pc;
  logic           eret;
  logic           intr_req;
  logic [IDB-1:0] intr_id;
  logic [PCB-1:0] epc;
  logic           intr_en;
  logic [N-1:0]   intr_mask;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic           m_ie, m_exl;
  logic [N-1:0]   m_im, m_pend, m_prev;
  logic [PCB-1:0] m_epc;

  cp0_intr_ctrl #(.N_IRQ(N), .PC_BITS(PCB), .ID_BITS(IDB)) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .w_req(w_req), .w_data(w_data),
    .r_req(r_req), .r_data(r_data), .irq(irq), .intr_ack(intr_ack),
    .ack_pc(ack_pc), .eret(eret), .intr_req(intr_req), .intr_id(intr_id),
    .epc(epc), .intr_en(intr_en), .intr_mask(intr_mask)
  );

  always #10 clk = ~clk;

  function automatic logic model_req();
    return m_ie && !m_exl && ((m_pend & m_im) != '0);
  endfunction

  function automatic int model_id();
    for (int i = 0; i < N; i++) begin
      if (m_pend[i] && m_im[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [4:0] r);
    case (r)
      5'd12:   return {20'h0, m_im, 6'h0, m_exl, m_ie};
      5'd13:   return {20'h0, m_pend, 8'h0};
      5'd14:   return {2'b00, m_epc};
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelReset();
    m_ie = 1'b0; m_exl = 1'b0; m_im = '0; m_pend = '0; m_prev = '0; m_epc = '0;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic readReg(input logic [4:0] r, output logic [31:0] v);
    r_req = r;
    #1;
    v = r_data;
  endtask

  // One clock of stimulus; also checks MFC0 sees the pre-edge value.
  task automatic applyStimulus(input logic [N-1:0] s_irq, input logic s_ack,
                               input logic [PCB-1:0] s_pc, input logic s_eret,
                               input logic s_we, input logic [4:0] s_wreq,
                               input logic [31:0] s_wdata);
    logic           fire;
    int             id;
    logic [N-1:0]   n_pend;
    logic           n_ie, n_exl;
    logic [N-1:0]   n_im;
    logic [PCB-1:0] n_epc;
    logic [4:0]     rr;
    @(negedge clk);
    irq = s_irq; intr_ack = s_ack; ack_pc = s_pc; eret = s_eret;
    w_en = s_we; w_req = s_wreq; w_data = s_wdata;
    rr = s_we ? s_wreq : 5'($urandom_range(0, 31));
    r_req = rr;
    #1;
    checkValue("mfc0_old", r_data, model_rdata(rr));

    fire   = s_ack && model_req();
    id     = model_id();
    n_pend = m_pend;
    if (fire) n_pend[id] = 1'b0;
    n_pend = n_pend | (s_irq & ~m_prev);
    n_ie   = m_ie;
    n_im   = m_im;
    if (s_we && s_wreq == 5'd12) begin
      n_ie = s_wdata[0];
      n_im = s_wdata[11:8];
    end
    if (fire)                         n_exl = 1'b1;
    else if (s_eret)                  n_exl = 1'b0;
    else if (s_we && s_wreq == 5'd12) n_exl = s_wdata[1];
    else                              n_exl = m_exl;
    if (fire)                         n_epc = s_pc;
    else if (s_we && s_wreq == 5'd14) n_epc = s_wdata[PCB-1:0];
    else                              n_epc = m_epc;

    @(posedge clk);
    m_pend = n_pend; m_ie = n_ie; m_im = n_im; m_exl = n_exl; m_epc = n_epc; m_prev = s_irq;
    #1;
    intr_ack = 1'b0; eret = 1'b0; w_en = 1'b0;
  endtask

  task automatic idle(input logic [N-1:0] s_irq);
    applyStimulus(s_irq, 1'b0, '0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic writeReg(input logic [N-1:0] s_irq, input logic [4:0] r, input logic [31:0] d);
    applyStimulus(s_irq, 1'b0, '0, 1'b0, 1'b1, r, d);
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] v;
    checkValue({tag, ":intr_req"},  {31'h0, intr_req}, {31'h0, model_req()});
    checkValue({tag, ":intr_id"},   32'(intr_id),      32'(model_id()));
    checkValue({tag, ":epc"},       32'(epc),          32'(m_epc));
    checkValue({tag, ":intr_en"},   {31'h0, intr_en},  {31'h0, m_ie});
    checkValue({tag, ":intr_mask"}, 32'(intr_mask),    32'(m_im));
    for (int r = 12; r <= 14; r++) begin
      readReg(5'(r), v);
      checkValue({tag, ":r_data"}, v, model_rdata(5'(r)));
    end
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1; w_en = 1'b0; w_req = '0; w_data = '0; r_req = '0;
    irq = '0; intr_ack = 1'b0; ack_pc = '0; eret = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset");
    checkValue("reset_req", {31'h0, intr_req}, 32'h0);

    // Test 1: mid-traffic reset with pending=0110
    writeReg(4'b0000, 5'd12, 32'h0000_0901);
    idle(4'b0110);
    checkOutput("t1_pre");
    readReg(5'd13, v); checkValue("t1_cause_pre", v, 32'h0000_0600);
    @(negedge clk); #1;
    rst = 1'b1; irq = '0;
    modelReset();
    #1;
    checkValue("t1_req", {31'h0, intr_req}, 32'h0);
    readReg(5'd12, v); checkValue("t1_status", v, 32'h0);
    readReg(5'd13, v); checkValue("t1_cause", v, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("t1_post");

    // Test 2
    writeReg(4'b0000, 5'd12, 32'h0000_0F01);
    idle(4'b0100);
    checkOutput("t2");
    checkValue("t2_req", {31'h0, intr_req}, 32'h1);
    checkValue("t2_id", 32'(intr_id), 32'd2);
    readReg(5'd13, v); checkValue("t2_cause", v, 32'h0000_0400);
    applyStimulus(4'b0100, 1'b1, 30'h20, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(4'b0100, 1'b0, '0, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("t2_done");

    // Test 3
    idle(4'b0000);
    idle(4'b1010);
    checkOutput("t3_pre");
    checkValue("t3_id", 32'(intr_id), 32'd1);
    applyStimulus(4'b1010, 1'b1, 30'h100, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("t3");
    checkValue("t3_req", {31'h0, intr_req}, 32'h0);
    readReg(5'd14, v); checkValue("t3_epc", v, 32'h0000_0100);
    readReg(5'd12, v); checkValue("t3_status", v, 32'h0000_0F03);
    readReg(5'd13, v); checkValue("t3_cause", v, 32'h0000_0800);

    // Test 4
    applyStimulus(4'b1010, 1'b0, '0, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("t4");
    readReg(5'd12, v); checkValue("t4_status", v, 32'h0000_0F01);
    checkValue("t4_req", {31'h0, intr_req}, 32'h1);
    checkValue("t4_id", 32'(intr_id), 32'd3);
    applyStimulus(4'b1010, 1'b1, 30'h200, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(4'b1010, 1'b0, '0, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("t4_done");

    // Test 5: held level, masked, then enabled and serviced once
    writeReg(4'b0000, 5'd12, 32'h0000_0E01);
    for (int i = 0; i < 10; i++) idle(4'b0001);
    checkOutput("t5_masked");
    checkValue("t5_req0", {31'h0, intr_req}, 32'h0);
    readReg(5'd13, v); checkValue("t5_cause", v, 32'h0000_0100);
    writeReg(4'b0001, 5'd12, 32'h0000_0F01);
    checkValue("t5_req1", {31'h0, intr_req}, 32'h1);
    checkValue("t5_id", 32'(intr_id), 32'd0);
    applyStimulus(4'b0001, 1'b1, 30'h300, 1'b0, 1'b0, 5'd0, 32'h0);
    checkValue("t5_ackreq", {31'h0, intr_req}, 32'h0);
    applyStimulus(4'b0001, 1'b0, '0, 1'b1, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) idle(4'b0001);
    checkOutput("t5_done");
    checkValue("t5_norereq", {31'h0, intr_req}, 32'h0);

    // Test 6: ack beats eret beats MTC0
    idle(4'b0000);
    idle(4'b0010);
    checkValue("t6_req", {31'h0, intr_req}, 32'h1);
    applyStimulus(4'b0010, 1'b1, 30'h44, 1'b1, 1'b1, 5'd14, 32'h88);
    checkOutput("t6");
    checkValue("t6_epc", 32'(epc), 32'h44);
    readReg(5'd12, v); checkValue("t6_status", v, 32'h0000_0F03);

    // Ignored ack, dropped Cause/unknown writes
    applyStimulus(4'b0010, 1'b1, 30'h55, 1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF);
    checkValue("ign_epc", 32'(epc), 32'h44);
    readReg(5'd13, v); checkValue("ign_cause", v, 32'h0);
    writeReg(4'b0010, 5'd9, 32'hFFFF_FFFF);
    applyStimulus(4'b0000, 1'b0, '0, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("ign");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0]  wr;
      logic [31:0] wd;
      int          sel;
      sel = $urandom_range(0, 3);
      wr  = (sel == 3) ? 5'($urandom_range(0, 31)) : 5'(12 + sel);
      wd  = $urandom;
      if ($urandom_range(0, 3) != 0) wd[0] = 1'b1;
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    30'($urandom), ($urandom_range(0, 9) < 2),
                    ($urandom_range(0, 9) < 3), wr, wd);
      checkOutput("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
